// File: rtl/sys_cmd_ctrl.sv
// Command-frame controller: parses RX byte frames into register-file and
// ALU requests, then returns the results as TX bytes under back-pressure.
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_WR      = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RD      = 8'hBB,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_rx_valid,
  input  logic [DATA_WIDTH-1:0]   i_rx_data,
  output logic [ADDR_WIDTH-1:0]   o_rf_addr,
  output logic                    o_rf_wr_en,
  output logic [DATA_WIDTH-1:0]   o_rf_wr_data,
  output logic                    o_rf_rd_en,
  input  logic [DATA_WIDTH-1:0]   i_rf_rd_data,
  input  logic                    i_rf_rd_valid,
  output logic                    o_alu_en,
  output logic [FUN_WIDTH-1:0]    o_alu_fun,
  input  logic [2*DATA_WIDTH-1:0] i_alu_out,
  input  logic                    i_alu_valid,
  output logic [DATA_WIDTH-1:0]   o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_full
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_TX_RD,
    S_TX_LO,
    S_TX_HI
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] RF_OP_A = '0;
  localparam logic [ADDR_WIDTH-1:0] RF_OP_B = ADDR_WIDTH'(1);

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_rd_byte;
  logic [2*DATA_WIDTH-1:0] r_alu_res;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_rd_byte    <= '0;
      r_alu_res    <= '0;
      o_rf_addr    <= '0;
      o_rf_wr_en   <= 1'b0;
      o_rf_wr_data <= '0;
      o_rf_rd_en   <= 1'b0;
      o_alu_en     <= 1'b0;
      o_alu_fun    <= '0;
      o_tx_data    <= '0;
      o_tx_valid   <= 1'b0;
    end else begin
      // strobes are single-cycle; only the active state re-asserts one
      o_rf_wr_en <= 1'b0;
      o_rf_rd_en <= 1'b0;
      o_alu_en   <= 1'b0;
      o_tx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_WR:      r_state <= S_WR_ADDR;
              CMD_RD:      r_state <= S_RD_ADDR;
              CMD_ALU_OP:  r_state <= S_ALU_A;
              CMD_ALU_NOP: r_state <= S_ALU_FUN;
              default:     r_state <= S_IDLE;
            endcase
          end
        end
        S_WR_ADDR: begin
          if (i_rx_valid) begin
            r_addr  <= i_rx_data[ADDR_WIDTH-1:0];
            r_state <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (i_rx_valid) begin
            o_rf_wr_en   <= 1'b1;
            o_rf_addr    <= r_addr;
            o_rf_wr_data <= i_rx_data;
            r_state      <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (i_rx_valid) begin
            o_rf_rd_en <= 1'b1;
            o_rf_addr  <= i_rx_data[ADDR_WIDTH-1:0];
            r_state    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (i_rf_rd_valid) begin
            r_rd_byte <= i_rf_rd_data;
            r_state   <= S_TX_RD;
          end
        end
        S_ALU_A: begin
          if (i_rx_valid) begin
            o_rf_wr_en   <= 1'b1;
            o_rf_addr    <= RF_OP_A;
            o_rf_wr_data <= i_rx_data;
            r_state      <= S_ALU_B;
          end
        end
        S_ALU_B: begin
          if (i_rx_valid) begin
            o_rf_wr_en   <= 1'b1;
            o_rf_addr    <= RF_OP_B;
            o_rf_wr_data <= i_rx_data;
            r_state      <= S_ALU_FUN;
          end
        end
        S_ALU_FUN: begin
          if (i_rx_valid) begin
            o_alu_en  <= 1'b1;
            o_alu_fun <= i_rx_data[FUN_WIDTH-1:0];
            r_state   <= S_ALU_WAIT;
          end
        end
        S_ALU_WAIT: begin
          if (i_alu_valid) begin
            r_alu_res <= i_alu_out;
            r_state   <= S_TX_LO;
          end
        end
        S_TX_RD: begin
          if (!i_tx_full) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= r_rd_byte;
            r_state    <= S_IDLE;
          end
        end
        S_TX_LO: begin
          if (!i_tx_full) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= r_alu_res[DATA_WIDTH-1:0];
            r_state    <= S_TX_HI;
          end
        end
        S_TX_HI: begin
          if (!i_tx_full) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= r_alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
